// File: rtl/task_ctrl_responder_if.sv
// Control/stream bundle for task_ctrl_responder: ap_* task handshake, start scalars,
// and the address beat stream with its valid/ready/last signals.
interface task_ctrl_responder_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int N_WIDTH    = 64
);
  logic                  ap_start;
  logic                  ap_ready;
  logic                  ap_done;
  logic                  ap_idle;
  logic [N_WIDTH-1:0]    n;
  logic [ADDR_WIDTH-1:0] base;
  logic                  out_valid;
  logic                  out_ready;
  logic [ADDR_WIDTH-1:0] out_data;
  logic                  out_last;

  modport master (
    output ap_start, n, base, out_ready,
    input  ap_ready, ap_done, ap_idle, out_valid, out_data, out_last
  );

  modport slave (
    input  ap_start, n, base, out_ready,
    output ap_ready, ap_done, ap_idle, out_valid, out_data, out_last
  );
endinterface

// File: rtl/task_ctrl_responder.sv
// Task responder: on start it latches n and base, then streams n address beats
// (base, base+STEP, ...) with fully registered, bubble-free valid/data/last.
module task_ctrl_responder #(
  parameter int ADDR_WIDTH = 64,
  parameter int N_WIDTH    = 64,
  parameter int STEP       = 8
) (
  input logic                   ap_clk,
  input logic                   ap_rst_n,
  task_ctrl_responder_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e                state_q, state_d;
  logic [N_WIDTH-1:0]    idx_q, idx_d;
  logic [N_WIDTH-1:0]    nLat_q, nLat_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  valid_q, valid_d;
  logic                  last_q, last_d;
  logic                  ready_q, ready_d;
  logic                  done_q, done_d;

  // addr_q is the latched base advanced by STEP per transfer, so no multiplier is needed.
  // last for the next beat is precomputed from idx_q+1, which never exceeds n-1 here.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    nLat_d  = nLat_q;
    addr_d  = addr_q;
    valid_d = valid_q;
    last_d  = last_q;
    ready_d = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.ap_start) begin
          nLat_d  = bus.n;
          addr_d  = bus.base;
          idx_d   = '0;
          ready_d = 1'b1;
          if (bus.n != '0) begin
            state_d = RUN;
            valid_d = 1'b1;
            last_d  = (bus.n == N_WIDTH'(1));
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      RUN: begin
        if (valid_q && bus.out_ready) begin
          idx_d = idx_q + N_WIDTH'(1);
          if (last_q) begin
            state_d = DONE;
            valid_d = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            addr_d = addr_q + ADDR_WIDTH'(STEP);
            last_d = ((idx_q + N_WIDTH'(1)) == (nLat_q - N_WIDTH'(1)));
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        last_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      nLat_q  <= '0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      nLat_q  <= nLat_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  assign bus.ap_idle   = (state_q == IDLE);
  assign bus.ap_ready  = ready_q;
  assign bus.ap_done   = done_q;
  assign bus.out_valid = valid_q;
  assign bus.out_data  = addr_q;
  assign bus.out_last  = last_q;

endmodule

// File: tb/tb_task_ctrl_responder.sv
// Bench for task_ctrl_responder: a queue-of-addresses task model checked every
// cycle, plus directed scenarios with literal expected values.
module tb_task_ctrl_responder;

  localparam int              AW   = 64;
  localparam int              NW   = 64;
  localparam longint unsigned STEP = 8;

  logic ap_clk   = 1'b0;
  logic ap_rst_n = 1'b1;

  task_ctrl_responder_if #(.ADDR_WIDTH(AW), .N_WIDTH(NW)) bus ();

  task_ctrl_responder #(.ADDR_WIDTH(AW), .N_WIDTH(NW), .STEP(8)) dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .bus      (bus)
  );

  always #5 ap_clk = ~ap_clk;

  int compared   = 0;
  int mismatched = 0;

  logic [AW-1:0] beatQ[$];
  logic [AW-1:0] txLog[$];
  logic          expIdle  = 1'b1;
  logic          expReady = 1'b0;
  logic          expDone  = 1'b0;
  logic          expValid = 1'b0;
  logic          expLast  = 1'b0;
  logic [AW-1:0] expData  = '0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic start, input logic [NW-1:0] nVal,
                               input logic [AW-1:0] baseVal, input logic rdy);
    bus.ap_start  = start;
    bus.n         = nVal;
    bus.base      = baseVal;
    bus.out_ready = rdy;
  endtask

  task automatic stepCycle();
    @(posedge ap_clk);
    #1;
  endtask

  // Task-level model: an accepted start expands into the full list of beat addresses;
  // each transfer pops one, and the pop that empties the list produces done next cycle.
  always @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      beatQ.delete();
      expIdle  = 1'b1;
      expReady = 1'b0;
      expDone  = 1'b0;
    end else begin
      logic nr, nd;
      nr = 1'b0;
      nd = 1'b0;
      if (expIdle && bus.ap_start) begin
        beatQ.delete();
        for (longint unsigned i = 0; i < bus.n; i++)
          beatQ.push_back(bus.base + i * STEP);
        nr      = 1'b1;
        expIdle = 1'b0;
        if (bus.n == 0) nd = 1'b1;
      end else if (beatQ.size() > 0 && bus.out_ready) begin
        void'(beatQ.pop_front());
        if (beatQ.size() == 0) nd = 1'b1;
      end else if (expDone) begin
        expIdle = 1'b1;
      end
      expReady = nr;
      expDone  = nd;
    end
    expValid = (beatQ.size() > 0);
    expData  = expValid ? beatQ[0] : '0;
    expLast  = (beatQ.size() == 1);
  end

  always @(negedge ap_clk) begin
    checkOutput("ap_idle",   {63'b0, bus.ap_idle},   {63'b0, expIdle});
    checkOutput("ap_ready",  {63'b0, bus.ap_ready},  {63'b0, expReady});
    checkOutput("ap_done",   {63'b0, bus.ap_done},   {63'b0, expDone});
    checkOutput("out_valid", {63'b0, bus.out_valid}, {63'b0, expValid});
    checkOutput("out_last",  {63'b0, bus.out_last},  {63'b0, expLast});
    if (expValid || !ap_rst_n)
      checkOutput("out_data", bus.out_data, expData);
    if (ap_rst_n && bus.out_valid && bus.out_ready)
      txLog.push_back(bus.out_data);
  end

  initial begin
    applyStimulus(1'b0, '0, '0, 1'b1);
    #1 ap_rst_n = 1'b0;
    #1;
    checkOutput("rst_idle", {63'b0, bus.ap_idle}, 64'd1);
    checkOutput("rst_data", bus.out_data, 64'd0);
    repeat (3) stepCycle();
    ap_rst_n = 1'b1;
    stepCycle();

    $display("[TB] scenario: n=4 streaming");
    txLog.delete();
    applyStimulus(1'b1, 64'd4, 64'h1000, 1'b1);
    stepCycle();
    bus.ap_start = 1'b0;
    checkOutput("s1_ready_T1", {63'b0, bus.ap_ready}, 64'd1);
    checkOutput("s1_beat0", bus.out_data, 64'h1000);
    checkOutput("s1_last0", {63'b0, bus.out_last}, 64'd0);
    repeat (3) stepCycle();
    checkOutput("s1_beat3", bus.out_data, 64'h1018);
    checkOutput("s1_last3", {63'b0, bus.out_last}, 64'd1);
    stepCycle();
    checkOutput("s1_done_T5", {63'b0, bus.ap_done}, 64'd1);
    stepCycle();
    checkOutput("s1_idle_T6", {63'b0, bus.ap_idle}, 64'd1);
    checkOutput("s1_count", 64'(txLog.size()), 64'd4);

    $display("[TB] scenario: n=0");
    applyStimulus(1'b1, 64'd0, 64'h7000, 1'b1);
    stepCycle();
    bus.ap_start = 1'b0;
    checkOutput("s2_ready", {63'b0, bus.ap_ready}, 64'd1);
    checkOutput("s2_done",  {63'b0, bus.ap_done},  64'd1);
    checkOutput("s2_valid", {63'b0, bus.out_valid}, 64'd0);
    stepCycle();
    checkOutput("s2_idle", {63'b0, bus.ap_idle}, 64'd1);

    $display("[TB] scenario: n=3 with stalls");
    txLog.delete();
    applyStimulus(1'b1, 64'd3, 64'h2000, 1'b1);
    stepCycle();
    bus.ap_start = 1'b0;
    stepCycle();
    bus.out_ready = 1'b0;
    checkOutput("s3_stall_data1", bus.out_data, 64'h2008);
    stepCycle();
    checkOutput("s3_stall_data2", bus.out_data, 64'h2008);
    checkOutput("s3_stall_valid", {63'b0, bus.out_valid}, 64'd1);
    stepCycle();
    bus.out_ready = 1'b1;
    stepCycle();
    checkOutput("s3_last_data", bus.out_data, 64'h2010);
    checkOutput("s3_last_flag", {63'b0, bus.out_last}, 64'd1);
    stepCycle();
    checkOutput("s3_done", {63'b0, bus.ap_done}, 64'd1);
    checkOutput("s3_count", 64'(txLog.size()), 64'd3);
    stepCycle();

    $display("[TB] scenario: address wrap");
    applyStimulus(1'b1, 64'd2, 64'hFFFF_FFFF_FFFF_FFF8, 1'b1);
    stepCycle();
    bus.ap_start = 1'b0;
    checkOutput("s4_beat0", bus.out_data, 64'hFFFF_FFFF_FFFF_FFF8);
    stepCycle();
    checkOutput("s4_beat1", bus.out_data, 64'h0);
    checkOutput("s4_last1", {63'b0, bus.out_last}, 64'd1);
    repeat (2) stepCycle();

    $display("[TB] scenario: reset mid-run");
    txLog.delete();
    applyStimulus(1'b1, 64'd5, 64'h3000, 1'b1);
    stepCycle();
    bus.ap_start = 1'b0;
    repeat (2) stepCycle();
    ap_rst_n = 1'b0;
    #1;
    checkOutput("s5_valid_rst", {63'b0, bus.out_valid}, 64'd0);
    checkOutput("s5_idle_rst",  {63'b0, bus.ap_idle},   64'd1);
    checkOutput("s5_done_rst",  {63'b0, bus.ap_done},   64'd0);
    repeat (2) stepCycle();
    ap_rst_n = 1'b1;
    repeat (2) stepCycle();
    checkOutput("s5_count", 64'(txLog.size()), 64'd2);
    applyStimulus(1'b1, 64'd1, 64'h4000, 1'b1);
    stepCycle();
    bus.ap_start = 1'b0;
    checkOutput("s5_new_beat", bus.out_data, 64'h4000);
    stepCycle();
    checkOutput("s5_new_done", {63'b0, bus.ap_done}, 64'd1);
    stepCycle();

    $display("[TB] scenario: held start, back-to-back");
    applyStimulus(1'b1, 64'd1, 64'h5000, 1'b1);
    stepCycle();
    bus.n    = 64'd7;
    bus.base = 64'h9990;
    checkOutput("s6_beat", bus.out_data, 64'h5000);
    stepCycle();
    checkOutput("s6_done", {63'b0, bus.ap_done}, 64'd1);
    bus.n    = 64'd1;
    bus.base = 64'h6000;
    stepCycle();
    checkOutput("s6_idle", {63'b0, bus.ap_idle}, 64'd1);
    stepCycle();
    bus.ap_start = 1'b0;
    checkOutput("s6_reaccept", {63'b0, bus.ap_ready}, 64'd1);
    checkOutput("s6_beat2", bus.out_data, 64'h6000);
    repeat (3) stepCycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/task_ctrl_responder.md
TASK_CTRL_RESPONDER -- requirements
Module: task_ctrl_responder

Interface
REQ-001 Parameter: ADDR_WIDTH, default 64, width of base address and output address beats.
REQ-002 Parameter: N_WIDTH, default 64, width of the iteration-count scalar n and the internal counter.
REQ-003 Parameter: STEP, default 8, address increment per beat, in bytes.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-low. The ports are ap_clk (in, 1) and ap_rst_n (in, 1).
REQ-005 ap_clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 ap_rst_n  in  1  asynchronous active-low reset.
REQ-007 ap_start  in  1  start request from the parent FSM, held high until ap_ready is seen.
REQ-008 ap_ready  out  1  one-cycle pulse: start accepted, scalars latched.
REQ-009 ap_done  out  1  one-cycle pulse: task complete.
REQ-010 ap_idle  out  1  high only while the block is in IDLE.
REQ-011 n  in  N_WIDTH  beat count scalar, sampled only at start acceptance.
REQ-012 base  in  ADDR_WIDTH  base address scalar, sampled only at start acceptance.
REQ-013 out_valid  out  1  output beat valid.
REQ-014 out_ready  in  1  downstream accepts the beat.
REQ-015 out_data  out  ADDR_WIDTH  beat payload, which is an address.
REQ-016 out_last  out  1  marks the final beat of the task.

Function
REQ-017 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-018 Start is accepted in cycle T iff the state is IDLE and ap_start=1. At acceptance the block latches n and base, clears idx to 0, and leaves ap_idle=0 from T+1.
REQ-019 ap_ready SHALL be a registered pulse, high in cycle T+1 only.
REQ-020 If the latched n != 0, the next state SHALL be RUN. If the latched n == 0, the next state SHALL be DONE, so that ap_ready and ap_done are both high in T+1.
REQ-021 In RUN: out_valid=1, out_data=base + idx*STEP (modulo 2^ADDR_WIDTH, wrap silently), and out_last=(idx == n-1).
REQ-022 A beat transfers when out_valid && out_ready. On a transfer, idx increments. On a transfer with out_last=1, the next state is DONE.
REQ-023 While out_valid=1 and out_ready=0, out_data, out_last and out_valid SHALL hold stable.
REQ-024 out_data, out_valid and out_last SHALL be registered. Bubble-free streaming is required: with out_ready held at 1, one beat transfers per cycle.
REQ-025 DONE SHALL last exactly one cycle: ap_done=1 and out_valid=0, then the state returns to IDLE.
REQ-026 ap_start is ignored in RUN and DONE; latched n and base SHALL NOT change until the next acceptance.
REQ-027 Back-to-back operation: after DONE in cycle D, ap_idle=1 in D+1, and a held ap_start is accepted in D+1.
REQ-028 Counter arithmetic: idx is N_WIDTH wide and unsigned. n = 2^N_WIDTH-1 is legal; no overflow occurs because the last index is n-1.
REQ-029 ap_ready and ap_done SHALL never be high for more than one consecutive cycle.

Reset
REQ-030 Asserting ap_rst_n=0 SHALL immediately force the following, independent of the clock: state=IDLE, ap_idle=1, ap_ready=0, ap_done=0, out_valid=0, out_last=0, out_data=0, idx=0, latched n=0, latched base=0.
REQ-031 Reset during RUN SHALL abort the task: no ap_done is issued and no further beats are emitted.
REQ-032 After ap_rst_n deasserts, the first start is accepted on the first rising edge with ap_start=1.

Verification
REQ-033 Scenario: n=4, base=0x1000, out_ready=1 -> ap_ready at T+1; beats 0x1000, 0x1008, 0x1010, 0x1018 in T+1..T+4 with out_last only on 0x1018; ap_done at T+5; ap_idle=1 at T+6.
REQ-034 Scenario: n=0 -> ap_ready=1 and ap_done=1 in the same cycle T+1; no beats; ap_idle=1 at T+2.
REQ-035 Scenario: n=3, out_ready toggling 1,0,0,1,1 -> exactly 3 transfers; payload held stable during stalls; ap_done one cycle after the third transfer.
REQ-036 Scenario: base=0xFFFF_FFFF_FFFF_FFF8, n=2 -> beats 0xFFFF_FFFF_FFFF_FFF8 then 0x0.
REQ-037 Scenario: ap_rst_n pulsed low mid-RUN after 2 of 5 beats -> out_valid=0 immediately; no ap_done; ap_idle=1; a new start with n=1 completes normally.
REQ-038 Scenario: ap_start held high continuously with n=1 -> accepted again in the cycle after ap_done; inputs changed during RUN do not affect the payload.
